// File: rtl/acumulador_productos_if.sv
// Bus bundle between the product accumulator, the upstream multiplier and the result consumer.
// The slave side is the accumulator; the master side is whoever drives products and takes sums.
interface acumulador_productos_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 8
);
  logic [2*WIDTH-1:0]         producto;
  logic                       Done_Flag;
  logic                       ack;
  logic [2*WIDTH+COUNT_W-1:0] suma;
  logic                       suma_valid;
  logic                       suma_ready;

  modport master (
    output producto, Done_Flag, suma_ready,
    input  ack, suma, suma_valid
  );

  modport slave (
    input  producto, Done_Flag, suma_ready,
    output ack, suma, suma_valid
  );
endinterface

// File: rtl/acumulador_productos.sv
// Accumulates a programmed number of multiplier products (Done_Flag/ack handshake)
// into a widened sum and offers it on a valid/ready port.
module acumulador_productos #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_W-1:0]     n_terms,
  output logic                   busy,
  acumulador_productos_if.slave  bus
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned SUMA_W = PROD_W + COUNT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    ACK    = 2'd2,
    SALIDA = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SUMA_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [COUNT_W-1:0]  nterms_q, nterms_d;
  logic [SUMA_W-1:0]   suma_q, suma_d;
  logic                ack_q, ack_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      nterms_q <= '0;
      suma_q   <= '0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      nterms_q <= nterms_d;
      suma_q   <= suma_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    nterms_d = nterms_q;
    suma_d   = suma_q;
    ack_d    = ack_q;
    valid_d  = valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          nterms_d = n_terms;
          acc_d    = '0;
          cnt_d    = '0;
          if (n_terms == '0) begin
            suma_d  = '0;
            valid_d = 1'b1;
            state_d = SALIDA;
          end else begin
            state_d = ESPERA;
          end
        end
      end

      ESPERA: begin
        if (bus.Done_Flag) begin
          acc_d   = acc_q + SUMA_W'(bus.producto);
          cnt_d   = cnt_q + COUNT_W'(1);
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end

      // Hold ack until the multiplier withdraws its flag; no re-accumulation here
      ACK: begin
        if (!bus.Done_Flag) begin
          ack_d = 1'b0;
          if (cnt_q == nterms_q) begin
            suma_d  = acc_q;
            valid_d = 1'b1;
            state_d = SALIDA;
          end else begin
            state_d = ESPERA;
          end
        end
      end

      SALIDA: begin
        if (bus.suma_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.ack        = ack_q;
  assign bus.suma       = suma_q;
  assign bus.suma_valid = valid_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_acumulador_productos.sv
// Randomized scoreboard bench for acumulador_productos with a behavioural multiplier model.
`timescale 1ns/1ps
module tb_acumulador_productos;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned SUMA_W  = 2 * WIDTH + COUNT_W;

  logic               clk;
  logic               reset;
  logic               start;
  logic [COUNT_W-1:0] n_terms;
  logic               busy;

  acumulador_productos_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

  acumulador_productos #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .n_terms (n_terms),
    .busy    (busy),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  logic ack_prev = 1'b0;
  logic [SUMA_W-1:0] exp_q[$];

  logic [63:0] prod_tab[8];
  int          hold_tab[8];

  task automatic chk(input string name, input logic [SUMA_W-1:0] act, input logic [SUMA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one pop per transfer (valid and ready both seen mid-cycle)
  always @(negedge clk) begin
    if (reset) begin
      if (bus.ack && !ack_prev) ack_cnt++;
      if (bus.suma_valid && bus.suma_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got suma %0h with no batch pending", bus.suma);
        end else begin
          logic [SUMA_W-1:0] e;
          e = exp_q.pop_front();
          chk("sb_suma", bus.suma, e);
        end
      end
    end
    ack_prev = bus.ack;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] mult(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // One product through the model multiplier: flag held for 'hold' edges, then dropped
  task automatic term(input logic [63:0] p, input int hold, input bit last, input string tag);
    int seen;
    seen = 0;
    bus.producto  = p;
    bus.Done_Flag = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.ack) seen++;
    end
    chk({tag, "_ack_hold"}, SUMA_W'(seen), SUMA_W'(hold));
    bus.Done_Flag = 1'b0;
    bus.producto  = {$urandom, $urandom};
    step();
    chk({tag, "_ack_fall"}, SUMA_W'(bus.ack), '0);
    if (last) chk({tag, "_valid_rise"}, SUMA_W'(bus.suma_valid), SUMA_W'(1));
  endtask

  task automatic batch(input int n, input int rdelay, input string tag);
    logic [SUMA_W-1:0] exp;
    int a0;
    exp = '0;
    for (int i = 0; i < n; i++) exp = exp + SUMA_W'(prod_tab[i]);
    exp_q.push_back(exp);
    a0 = ack_cnt;
    bus.suma_ready = (rdelay == 0);
    start   = 1'b1;
    n_terms = COUNT_W'(n);
    step();
    start   = 1'b0;
    n_terms = COUNT_W'($urandom);
    chk({tag, "_busy"}, SUMA_W'(busy), SUMA_W'(1));
    for (int i = 0; i < n; i++) term(prod_tab[i], hold_tab[i], (i == n - 1), tag);
    if (n == 0) begin
      chk({tag, "_zero_valid"}, SUMA_W'(bus.suma_valid), SUMA_W'(1));
      chk({tag, "_zero_suma"}, bus.suma, '0);
    end
    if (rdelay > 0) begin
      for (int i = 0; i < rdelay; i++) step();
      bus.suma_ready = 1'b1;
    end
    for (int i = 0; i < 20 && busy; i++) step();
    chk({tag, "_idle"}, SUMA_W'(busy), '0);
    chk({tag, "_ack_pulses"}, SUMA_W'(ack_cnt - a0), SUMA_W'(n));
  endtask

  initial begin
    logic [63:0] ff;
    logic [SUMA_W-1:0] held;
    int idle_ok;
    int stable_bad;

    reset = 1'b0;
    start = 1'b0;
    n_terms = '0;
    bus.producto = '0;
    bus.Done_Flag = 1'b0;
    bus.suma_ready = 1'b0;
    #3;
    chk("rst_ack", SUMA_W'(bus.ack), '0);
    chk("rst_suma", bus.suma, '0);
    chk("rst_valid", SUMA_W'(bus.suma_valid), '0);
    chk("rst_busy", SUMA_W'(busy), '0);
    step();
    step();
    reset = 1'b1;
    idle_ok = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!busy) idle_ok++;
    end
    chk("idle_after_reset", SUMA_W'(idle_ok), SUMA_W'(5));

    // Single term, max operands
    ff = mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    prod_tab[0] = ff; hold_tab[0] = 1;
    batch(1, 0, "one");
    chk("one_suma", bus.suma, 72'h00_FFFFFFFE_00000001);

    // Three terms, same operands, varied flag lengths and backpressure
    for (int i = 0; i < 3; i++) begin prod_tab[i] = ff; hold_tab[i] = i + 1; end
    batch(3, 2, "three");
    chk("three_suma", bus.suma, 72'h02_FFFFFFFA_00000003);

    batch(0, 0, "zero");
    batch(0, 3, "zero_bp");

    // Sticky Done_Flag: a long flag must not re-accumulate
    prod_tab[0] = 64'd5; hold_tab[0] = 6;
    prod_tab[1] = 64'd7; hold_tab[1] = 1;
    batch(2, 0, "sticky");
    chk("sticky_suma", bus.suma, SUMA_W'(12));

    // Backpressure: result held, start ignored, including at the transfer edge
    prod_tab[0] = mult(32'h1234_5678, 32'h9ABC_DEF0);
    exp_q.push_back(SUMA_W'(prod_tab[0]));
    bus.suma_ready = 1'b0;
    start = 1'b1; n_terms = COUNT_W'(1);
    step();
    start = 1'b0;
    term(prod_tab[0], 2, 1'b1, "bp");
    held = bus.suma;
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin start = 1'b1; n_terms = '0; end
      step();
      start = 1'b0;
      if (bus.suma !== held || !bus.suma_valid) stable_bad++;
    end
    chk("bp_stable", SUMA_W'(stable_bad), '0);
    chk("bp_suma", bus.suma, SUMA_W'(prod_tab[0]));
    bus.suma_ready = 1'b1;
    start = 1'b1; n_terms = COUNT_W'(1);
    step();
    start = 1'b0;
    chk("bp_idle_next", SUMA_W'(busy), '0);
    chk("bp_valid_drop", SUMA_W'(bus.suma_valid), '0);
    step();
    chk("bp_start_ignored", SUMA_W'(busy), '0);
    chk("bp_suma_kept", bus.suma, SUMA_W'(prod_tab[0]));

    // Abort after one of three terms with an asynchronous mid-cycle reset
    prod_tab[0] = 64'd1000;
    exp_q.push_back(SUMA_W'(3000));
    start = 1'b1; n_terms = COUNT_W'(3);
    step();
    start = 1'b0;
    term(prod_tab[0], 1, 1'b0, "abort");
    bus.producto = 64'd1000;
    bus.Done_Flag = 1'b1;
    step();
    #1 reset = 1'b0;
    #1;
    chk("abort_ack", SUMA_W'(bus.ack), '0);
    chk("abort_suma", bus.suma, '0);
    chk("abort_valid", SUMA_W'(bus.suma_valid), '0);
    chk("abort_busy", SUMA_W'(busy), '0);
    exp_q.delete();
    bus.Done_Flag = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    prod_tab[0] = 64'd77; hold_tab[0] = 2;
    batch(1, 0, "post_abort");
    chk("post_abort_suma", bus.suma, SUMA_W'(77));

    // Randomized batches against the arithmetic model
    for (int b = 0; b < 10; b++) begin
      int n;
      int rd;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        prod_tab[i] = mult($urandom, $urandom);
        hold_tab[i] = $urandom_range(1, 4);
      end
      rd = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      batch(n, rd, "rand");
      for (int i = 0; i < $urandom_range(0, 3); i++) step();
    end

    step();
    chk("sb_leftover", SUMA_W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acumulador_productos.md
# acumulador_productos

Downstream consumer of the `multiplicador` stage. It takes each 2·WIDTH-bit `producto` that the multiplier presents with `Done_Flag`, acknowledges it with `ack`, and adds it into a widened accumulator. After a programmed number of terms it presents the sum on a valid/ready output port. Together with the multiplier it forms a multiply-accumulate (dot-product) path.

## Interface
- `WIDTH`, 32: multiplier operand width; `producto` is 2·WIDTH bits.
- `COUNT_W`, 8: term-counter width; a batch holds at most 2^COUNT_W−1 terms.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1: batch start pulse; sampled only in IDLE.
- `n_terms`  in  COUNT_W: number of products in the batch; latched when `start` is accepted.
- `producto`  in  2·WIDTH: product from the multiplier; must be stable while `Done_Flag`=1.
- `Done_Flag`  in  1: multiplier result-ready flag.
- `ack`  out  1: registered acknowledge to the multiplier.
- `suma`  out  2·WIDTH+COUNT_W: accumulated result.
- `suma_valid`  out  1: `suma` is valid.
- `suma_ready`  in  1: downstream accepts `suma`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Accumulator width is 2·WIDTH+COUNT_W. Each `producto` is zero-extended before it is added, so overflow cannot occur for any legal `n_terms`.
- States: IDLE, ESPERA (wait for product), ACK (acknowledge held), SALIDA (result offered).
- IDLE
  - `start`=1 latches `n_terms` and clears the accumulator and counter.
  - If `n_terms`=0, go to SALIDA with `suma`=0; otherwise go to ESPERA.
- ESPERA
  - `Done_Flag`=1 sampled: acc ← acc + `producto`, cnt ← cnt+1, `ack` ← 1, go to ACK.
- ACK
  - While `Done_Flag`=1: hold `ack`=1 and do not accumulate again.
  - When `Done_Flag`=0 is sampled: `ack` ← 0.
  - If cnt = latched `n_terms`, go to SALIDA with `suma` ← acc; otherwise go to ESPERA.
- SALIDA
  - `suma_valid`=1 and `suma` is held stable.
  - `suma_ready`=1 sampled: `suma_valid` ← 0, go to IDLE.
  - `suma` keeps its value after the transfer until the next batch completes.
- `start` outside IDLE is ignored, including in the same cycle as a SALIDA→IDLE transfer.
- `n_terms` and `producto` changes while not being sampled have no effect.
- Reset (`reset`=0) at any time abandons the batch:
  - state goes to IDLE; accumulator, counter and `suma` go to 0;
  - `ack`, `suma_valid` and `busy` go to 0;
  - the multiplier must be reset in the same cycle.

## Timing
- Reset values of all outputs: `ack`=0, `suma`=0, `suma_valid`=0, `busy`=0.
- All outputs are registered. No combinational path runs from any input to any output.
- `busy` rises on the cycle after the `start` edge.
- `ack` rises one cycle after the first edge that samples `Done_Flag`=1. It falls one cycle after the first edge that samples `Done_Flag`=0.
- Per-term handshake overhead is at least 3 cycles beyond multiplier latency: capture edge, multiplier drop edge, release edge.
- Last term: `suma_valid` rises on the same edge on which `ack` falls.
- `n_terms`=0: `suma_valid`=1 one cycle after `start` is accepted.
- The transfer occurs on the edge where `suma_valid`=`suma_ready`=1. `suma_ready` may be held high permanently, which gives a single-cycle `suma_valid` pulse.

## Test plan
- Reset: drive `reset`=0 mid-clock, asynchronously. Every output reads 0 before the next clk edge. Release, then idle 5 cycles with `busy`=0.
- Single term: `n_terms`=1, a=b=0xFFFFFFFF through `multiplicador`. Require `ack` to pulse once and `suma`=0x00_FFFFFFFE_00000001 with `suma_valid`=1.
- Three terms, same operands: require exactly 3 `ack` pulses and `suma`=0x02_FFFFFFFA_00000003.
- `n_terms`=0: `suma_valid`=1 and `suma`=0 one cycle after `start`. No `ack` is ever asserted.
- Sticky `Done_Flag`: a model multiplier holds `Done_Flag` for 6 cycles with `producto`=5, `n_terms`=2, second product=7. Require `ack` high for the full 6 cycles and `suma`=12, not 5·k+7.
- Backpressure and abort:
  - Hold `suma_ready`=0 for 10 cycles. Require `suma` stable and `suma_valid` held. Pulse `start` during this window; it is ignored. Then set `suma_ready`=1 and require IDLE next cycle.
  - Separately, assert `reset`=0 after 1 of 3 terms. Require all outputs 0 and that a new 1-term batch returns only its own product.
